// File: rtl/pc_unit.sv
// Program-counter unit: sequential PC advance with branch/jump/call/return redirects
// and a circular return-address stack that silently drops the oldest entry on overflow.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               DEPTH        = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             push_en;
    logic [PW-1:0]    top_idx;
    logic [WIDTH-1:0] ras_mem [DEPTH];

    // ptr_q is the next free slot; the most recent entry sits one below it.
    assign top_idx   = ptr_q - PW'(1);
    assign PC        = pc_q;
    assign PC4       = pc_q + WIDTH'(INC);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(DEPTH));
    assign ras_err   = err_q;

    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (!ras_empty) begin
                pc_d  = ras_mem[top_idx];
                ptr_d = top_idx;
                cnt_d = cnt_q - CW'(1);
            end else begin
                pc_d  = PC4;
                err_d = 1'b1;
            end
        end else if (call) begin
            pc_d    = jump_target;
            push_en = 1'b1;
            ptr_d   = ptr_q + PW'(1);
            // When full the write lands on the oldest slot, so the count saturates.
            if (!ras_full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (jump) begin
            pc_d = jump_target;
        end else if (branch_taken) begin
            pc_d = branch_target;
        end else begin
            pc_d = PC4;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) begin
            ras_mem[ptr_q] <= PC4;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequencing, stall, call/return stack, priority and reset.
module tb_pc_unit;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic        call;
    logic        ret;
    logic [31:0] jump_target;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int n_checks = 0;
    int n_errors = 0;

    pc_unit #(
        .WIDTH(32),
        .INC(4),
        .RESET_VECTOR(32'h0),
        .DEPTH(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .call(call),
        .ret(ret),
        .jump_target(jump_target),
        .PC(PC),
        .PC4(PC4),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ras_err(ras_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
    endtask

    logic [31:0] ret_exp [4];

    initial begin
        reset_n = 0; idle(); branch_target = '0; jump_target = '0;
        #12;
        check("rst_pc", PC, 32'h0);
        check("rst_pc4", PC4, 32'h4);
        check("rst_empty", 32'(ras_empty), 32'd1);
        check("rst_full", 32'(ras_full), 32'd0);
        check("rst_err", 32'(ras_err), 32'd0);
        reset_n = 1;

        // Sequential advance
        tick(); check("seq_pc1", PC, 32'h4);  check("seq_pc4_1", PC4, 32'h8);
        tick(); check("seq_pc2", PC, 32'h8);  check("seq_pc4_2", PC4, 32'hC);

        // Stall overrides a pending jump
        stall = 1; jump = 1; jump_target = 32'h100;
        tick(); check("stall_1", PC, 32'h8);
        tick(); check("stall_2", PC, 32'h8);
        stall = 0;
        tick(); check("jump_after_stall", PC, 32'h100);

        // Single call / return
        jump_target = 32'h10;
        tick(); check("jump_0x10", PC, 32'h10);
        jump = 0; call = 1; jump_target = 32'h200;
        tick(); check("call_pc", PC, 32'h200);
        check("call_not_empty", 32'(ras_empty), 32'd0);
        call = 0; ret = 1;
        tick(); check("ret_pc", PC, 32'h14);
        check("ret_empty", 32'(ras_empty), 32'd1);
        ret = 0;

        // Five nested calls overflow a 4-deep stack; oldest (0x18) is lost
        call = 1;
        for (int i = 1; i <= 5; i++) begin
            jump_target = 32'(i) << 12;
            tick();
            check("nest_pc", PC, 32'(i) << 12);
            if (i == 4) check("nest_full4", 32'(ras_full), 32'd1);
        end
        check("nest_full5", 32'(ras_full), 32'd1);
        check("nest_empty5", 32'(ras_empty), 32'd0);
        call = 0; ret = 1;
        ret_exp[0] = 32'h4004; ret_exp[1] = 32'h3004;
        ret_exp[2] = 32'h2004; ret_exp[3] = 32'h1004;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("unwind_pc", PC, ret_exp[i]);
            check("unwind_err", 32'(ras_err), 32'd0);
        end
        check("unwind_empty", 32'(ras_empty), 32'd1);
        tick(); check("underflow_pc", PC, 32'h1008);
        check("underflow_err", 32'(ras_err), 32'd1);
        ret = 0;
        tick(); check("err_sticky_pc", PC, 32'h100C);
        check("err_sticky", 32'(ras_err), 32'd1);

        // ret + call + branch with two entries: pop wins, count drops by one
        call = 1; jump_target = 32'h600;
        tick(); check("pri_call1", PC, 32'h600);
        jump_target = 32'h700;
        tick(); check("pri_call2", PC, 32'h700);
        ret = 1; call = 1; branch_taken = 1; jump_target = 32'h800; branch_target = 32'h900;
        tick(); check("pri_ret_wins", PC, 32'h604);
        check("pri_not_empty", 32'(ras_empty), 32'd0);
        call = 0; branch_taken = 0;
        tick(); check("pri_ret2", PC, 32'h1010);
        check("pri_empty", 32'(ras_empty), 32'd1);
        ret = 0;

        // Jump beats branch; branch alone redirects
        jump = 1; branch_taken = 1; jump_target = 32'hA00; branch_target = 32'hB00;
        tick(); check("jump_over_branch", PC, 32'hA00);
        jump = 0;
        tick(); check("branch_pc", PC, 32'hB00);
        branch_taken = 0;
        tick(); check("branch_then_seq", PC, 32'hB04);

        // Wrap at top of address space
        jump = 1; jump_target = 32'hFFFF_FFFC;
        tick(); check("top_pc", PC, 32'hFFFF_FFFC);
        check("top_pc4_wrap", PC4, 32'h0);
        jump = 0;
        tick(); check("wrap_pc", PC, 32'h0);

        // Asynchronous reset mid-cycle with a non-empty stack and sticky error set
        call = 1; jump_target = 32'h40;
        tick(); check("pre_rst_pc", PC, 32'h40);
        call = 0; stall = 1;
        #2 reset_n = 0;
        #1;
        check("async_rst_pc", PC, 32'h0);
        check("async_rst_empty", 32'(ras_empty), 32'd1);
        check("async_rst_err", 32'(ras_err), 32'd0);
        #2 reset_n = 1;
        stall = 0;
        tick(); check("post_rst_pc", PC, 32'h4);
        ret = 1;
        tick(); check("post_rst_ret_empty", PC, 32'h8);
        ret = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
